// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a fixed WIDTH-cycle latency for every op.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] result_q, result_d;

   // Operand decode for the op being accepted.
   logic             is_div_in, a_signed_in, b_signed_in, sa_in, sb_in, b_zero_in;
   logic [WIDTH-1:0] a_mag_in, b_mag_in;

   always_comb begin
      is_div_in   = Funct3[2];
      a_signed_in = is_div_in ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
      b_signed_in = is_div_in ? ~Funct3[0] : ~Funct3[1];
      sa_in       = a_signed_in & SrcA[WIDTH-1];
      sb_in       = b_signed_in & SrcB[WIDTH-1];
      a_mag_in    = sa_in ? -SrcA : SrcA;
      b_mag_in    = sb_in ? -SrcB : SrcB;
      b_zero_in   = (SrcB == '0);
   end

   // One iteration. Multiply: {hi,lo} is the product shifting right, opnd is the multiplicand.
   // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic               unused_diff_bit;

   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh   = {hi_q, lo_q[WIDTH-1]};
      div_diff = {1'b0, rem_sh} - {2'b0, opnd_q};
      div_ok   = ~div_diff[WIDTH+1];
      if (op_q[2]) begin
         step_hi = div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
         step_lo = {lo_q[WIDTH-2:0], div_ok};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // A successful subtract always leaves a remainder below the divisor, so this bit is zero.
   assign unused_diff_bit = div_diff[WIDTH];

   // Sign correction applied on the final iteration.
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   div_val, fin_val;

   always_comb begin
      prod     = {step_hi, step_lo};
      prod_fix = neg_q ? -prod : prod;
      div_val  = op_q[1] ? step_hi : step_lo;
      if (op_q[2]) begin
         fin_val = neg_q ? -div_val : div_val;
      end else if (op_q[1:0] == 2'b00) begin
         fin_val = prod_fix[WIDTH-1:0];
      end else begin
         fin_val = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;

      case (state_q)
         StIdle, StDone: begin
            if (start && !flush) begin
               state_d = StCalc;
               cnt_d   = '0;
               op_d    = Funct3;
               hi_d    = '0;
               if (is_div_in) begin
                  opnd_d = b_mag_in;
                  lo_d   = a_mag_in;
                  // Divide-by-zero quotient stays all ones regardless of the dividend sign.
                  neg_d  = Funct3[1] ? sa_in : ((sa_in ^ sb_in) & ~b_zero_in);
               end else begin
                  opnd_d = a_mag_in;
                  lo_d   = b_mag_in;
                  neg_d  = sa_in ^ sb_in;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StCalc: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               hi_d  = step_hi;
               lo_d  = step_lo;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastIter) begin
                  state_d  = StDone;
                  result_d = fin_val;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == StCalc);
   assign done   = (state_q == StDone);
   assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written handshake/flush/reset sequences.
module tb_muldiv_sequencer;

   localparam int unsigned W = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          flush;
   logic [2:0]    Funct3;
   logic [W-1:0]  SrcA;
   logic [W-1:0]  SrcB;
   logic          busy;
   logic          done;
   logic [W-1:0]  Result;

   int            checks;
   int            errors;
   logic [W-1:0]  last_res;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .flush  (flush),
      .Funct3 (Funct3),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .busy   (busy),
      .done   (done),
      .Result (Result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[14];

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      int          ia, ib;
      longint      sa, sb, ub;
      logic [63:0] p;
      logic [W-1:0] r;
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      ub = {32'h0, b};
      case (f)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = ia / ib;
         end
         3'd5: r = (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else r = ia % ib;
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Start in cycle 0; busy for cycles 1..W; done with the result in cycle W+1.
   task automatic do_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string nm);
      int nbusy;
      logic bad;
      Funct3 = f;
      SrcA   = a;
      SrcB   = b;
      start  = 1'b1;
      cycle();
      start  = 1'b0;
      SrcA   = $urandom;
      SrcB   = $urandom;
      Funct3 = 3'($urandom_range(0, 7));
      nbusy  = 0;
      bad    = 1'b0;
      for (int i = 1; i <= int'(W); i++) begin
         if (busy) nbusy++;
         if (done || Result !== last_res) bad = 1'b1;
         cycle();
      end
      check({nm, " busy cycles"}, W'(nbusy), W'(W));
      check({nm, " held during calc"}, W'(bad), '0);
      check({nm, " done cycle"}, W'({done, busy}), W'(2'b10));
      check({nm, " result"}, Result, exp);
      last_res = exp;
      cycle();
      check({nm, " done one cycle"}, W'({done, busy}), '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]   f;
      logic [W-1:0] a, b, e1, e2, r_seen;
      int           ndone, dcyc, n;
      logic         bad;

      checks   = 0;
      errors   = 0;
      last_res = '0;
      rst_n    = 1'b0;
      start    = 1'b0;
      flush    = 1'b0;
      Funct3   = '0;
      SrcA     = '0;
      SrcB     = '0;

      vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
      vecs[4]  = '{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF};
      vecs[5]  = '{3'd7, 32'd100,       32'd0,         32'd100};
      vecs[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
      vecs[8]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
      vecs[9]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
      vecs[10] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
      vecs[11] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
      vecs[12] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
      vecs[13] = '{3'd5, 32'd1000,      32'd7,         32'd142};

      repeat (2) cycle();
      check("reset state", {busy, done, Result[29:0]}, '0);
      rst_n = 1'b1;
      cycle();
      check("after reset release", {busy, done, Result[29:0]}, '0);

      foreach (vecs[i]) begin
         do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = W'($urandom_range(1, 15));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: a = W'($urandom_range(0, 1000));
            default: ;
         endcase
         do_op(f, a, b, ref_model(f, a, b), $sformatf("rand%0d f%0d", i, f));
      end

      // Second start while busy must be ignored.
      e1 = ref_model(3'd3, 32'hDEAD_BEEF, 32'h1357_9BDF);
      ndone = 0;
      dcyc = -1;
      r_seen = '0;
      for (int c = 0; c <= 45; c++) begin
         if (done) begin
            ndone++;
            dcyc = c;
            r_seen = Result;
         end
         start = (c == 5) || (c == 10);
         if (c == 5) begin
            Funct3 = 3'd3; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1357_9BDF;
         end
         if (c == 10) begin
            Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd5;
         end
         cycle();
      end
      start = 1'b0;
      check("busy start: done count", W'(ndone), W'(1));
      check("busy start: done cycle", W'(dcyc), W'(38));
      check("busy start: result", r_seen, e1);
      last_res = e1;

      // Back-to-back: start held in the done cycle.
      e1 = ref_model(3'd4, 32'hFFFF_FF00, 32'd9);
      e2 = ref_model(3'd1, 32'h7654_3210, 32'hF0F0_F0F0);
      Funct3 = 3'd4; SrcA = 32'hFFFF_FF00; SrcB = 32'd9;
      start = 1'b1;
      cycle();
      start = 1'b0;
      n = 1;
      while (!done && n < 40) begin
         cycle();
         n++;
      end
      check("b2b: first latency", W'(n), W'(33));
      check("b2b: first result", Result, e1);
      Funct3 = 3'd1; SrcA = 32'h7654_3210; SrcB = 32'hF0F0_F0F0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("b2b: accepted in done", W'({busy, done}), W'(2'b10));
      n = 1;
      while (!done && n < 40) begin
         cycle();
         n++;
      end
      check("b2b: second latency", W'(n), W'(33));
      check("b2b: second result", Result, e2);
      last_res = e2;
      cycle();

      // Flush a DIV at cycle 12.
      Funct3 = 3'd4; SrcA = 32'd12345; SrcB = 32'd17;
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (11) cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      check("flush: busy drops", W'({busy, done}), '0);
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy || Result !== last_res) bad = 1'b1;
         cycle();
      end
      check("flush: no done, result held", W'(bad), '0);
      do_op(3'd4, 32'd12345, 32'd17, 32'd726, "after flush");

      // Flush suppresses a simultaneous start in idle.
      Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd5;
      start = 1'b1;
      flush = 1'b1;
      cycle();
      start = 1'b0;
      flush = 1'b0;
      check("flush+start idle", W'({busy, done}), '0);

      // Asynchronous reset in the middle of a MUL.
      Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd11;
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (19) cycle();
      check("pre-reset busy", W'(busy), W'(1));
      #2 rst_n = 1'b0;
      #1;
      check("async reset outputs", {busy, done, Result[29:0]}, '0);
      last_res = '0;
      cycle();
      cycle();
      rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy || Result !== '0) bad = 1'b1;
         cycle();
      end
      check("after reset: no done", W'(bad), '0);
      do_op(3'd0, 32'd9, 32'd11, 32'd99, "after reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM.
- Sits beside the main ALU in the execute stage and is selected when Funct7 == 7'b0000001 on an R-type instruction.
- Accepts one operation per start pulse and computes the result radix-2, one bit per cycle.
- Reports completion with a one-cycle done pulse and holds the result until the next operation is accepted.

Parameters:
- WIDTH, 32, operand and result width in bits; iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- flush  input  1  abort the operation in flight (pipeline kill).
- Funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  WIDTH  rs1 operand (multiplicand / dividend).
- SrcB  input  WIDTH  rs2 operand (multiplier / divisor).
- busy  output  1  high while an operation is in flight; the stall request to the hazard unit.
- done  output  1  one-cycle pulse: Result is valid.
- Result  output  WIDTH  registered result; held until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy = 0; done = 0; Result = 0; counter and internal registers cleared.
  - Reset asserted mid-operation discards the operation with no done pulse.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 at edge k latches Funct3, SrcA and SrcB. Go to CALC.
  - CALC: busy=1. Counter runs 0..WIDTH-1, one iteration per cycle.
  - After WIDTH iterations, go to DONE. The final sign correction and Result register write happen on the same edge.
  - DONE: done=1, busy=0 for exactly one cycle. Next state is IDLE, or CALC if start=1 in that cycle (back-to-back accepted).
- Latency:
  - start at edge k → busy high for cycles k+1..k+WIDTH → done high in cycle k+WIDTH+1.
  - Latency is fixed for every op, including the special cases below.
- start while in CALC is ignored. The latched operands are unaffected.
- flush:
  - In CALC: go to IDLE on the next edge; no done; Result keeps its previous value.
  - flush has priority over start in the same cycle.
  - In IDLE or DONE: no effect, except that it suppresses a simultaneous start.
- Multiply (shift-add on magnitudes):
  - Operands are converted to magnitude according to signedness: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - The 2×WIDTH product is negated at finish if the signs differ.
  - MUL returns the low WIDTH bits; MULH, MULHSU and MULHU return the high WIDTH bits.
- Divide (restoring, on magnitudes; DIV/REM signed, DIVU/REMU unsigned):
  - Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A).
- Special cases (still take full latency):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → SrcA.
  - Signed overflow (SrcA = 1<<(WIDTH-1), SrcB = all ones): DIV → SrcA; REM → 0.
- Result changes only on the CALC→DONE edge. It is stable in all other cycles.

Test Plan:
- MUL: SrcA=7, SrcB=0xFFFFFFFD, start at cycle 0 → busy cycles 1–32, done in cycle 33, Result=0xFFFFFFEB.
- MULH / MULHU:
  - MULH 0x80000000×0x80000000 → Result=0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → Result=0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → Result=0xFFFFFFFF.
- Divide corners:
  - DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
- Handshake:
  - start pulses at cycles 5 and 10 (busy) → second ignored; exactly one done, in cycle 38.
  - start held in the done cycle → the new op is accepted; second done 33 cycles later.
- flush at cycle 12 of a DIV → busy=0 from next cycle, no done, Result unchanged from the previous op; the next start completes normally.
- rst_n low at cycle 20 of a MUL → busy, done and Result = 0 immediately (asynchronous); no done after release; a fresh op after release gives the correct result.
